game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES, default 3: lives loaded at game start, range 1..3.
REQ-002 Parameter SERVE_TICKS, default 4: ticks spent in SERVE before play.
REQ-003 Parameter STEP_DIV, default 2: ticks per step_en at level 0, range 1..15.
REQ-004 clock  in  1  system clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 tick  in  1  one-clock pulse, game time base (2 Hz domain strobe).
REQ-007 start_key  in  1  level; start or restart request.
REQ-008 pause_key  in  1  level; pause toggle request.
REQ-009 ball_lost  in  1  one-clock pulse; ball passed the plate row.
REQ-010 bricks  in  56  live-brick bitmap; all-zero means cleared.
REQ-011 state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, WIN=5, OVER=6.
REQ-012 step_en  out  1  one-clock pulse; plate, ball and score advance one step.
REQ-013 serve_req  out  1  high throughout SERVE; ball held on plate.
REQ-014 clear_req  out  1  one-clock pulse; reload bricks and zero score.
REQ-015 lives  out  2  remaining lives.
REQ-016 level  out  3  current level, 0..7.
REQ-017 game_over  out  1  high in OVER.

Function
REQ-018 start_key and pause_key SHALL be rising-edge detected against a registered previous value, so one press equals one event.
REQ-019 IDLE: on a start edge, go to SERVE, pulse clear_req, load lives=LIVES and level=0.
REQ-020 SERVE: count ticks; on the SERVE_TICKS-th tick, go to PLAY with the step counter cleared.
REQ-021 PLAY: pulse step_en on every Nth tick, same cycle as the tick, with N = max(1, STEP_DIV - level).
REQ-022 PLAY priority, highest first:
  - bricks==0 -> WIN
  - ball_lost -> LOST
  - pause edge -> PAUSE
REQ-023 No step_en SHALL be issued on the cycle PLAY is left.
REQ-024 PAUSE: no step_en; ticks ignored; the step counter is held; a pause edge returns to PLAY.
REQ-025 PAUSE: a start edge returns to IDLE.
REQ-026 LOST, one cycle: if lives==1, set lives=0 and go to OVER; otherwise decrement lives and go to SERVE.
REQ-027 WIN, one cycle: level increments and saturates at 7; pulse clear_req; go to SERVE; lives are unchanged.
REQ-028 OVER: game_over=1; a start edge behaves as in REQ-019.
REQ-029 ball_lost or a bricks change outside PLAY SHALL be ignored.
REQ-030 All outputs SHALL be registered; state changes take effect one clock after the qualifying input.
REQ-031 Tick counters SHALL be 4 bits and SHALL be cleared on every state entry.

Reset
REQ-032 reset low SHALL immediately force:
  - state=IDLE, lives=0, level=0
  - step_en, serve_req, clear_req and game_over all 0
  - all counters and edge registers cleared
REQ-033 Reset asserted mid-game SHALL abandon the game; no clear_req is issued on reset release.

Configuration
REQ-034 Macro GAME_SEQUENCER_PAUSE_EN SHALL control the PAUSE feature.
REQ-035 With GAME_SEQUENCER_PAUSE_EN defined, behaviour is as REQ-024 and REQ-025.
REQ-036 Without it, pause_key SHALL be ignored, PAUSE SHALL be unreachable, and state never reads 3.

Verification
REQ-037 Reset low mid-PLAY -> state=0, lives=0, level=0, no step_en; after release, idle until a start edge.
REQ-038 Start edge -> clear_req for 1 clock, state=1, lives=3; after 4 ticks, state=2; with level 0, step_en on every 2nd tick.
REQ-039 In PLAY, ball_lost three times, each followed by reserve -> lives 3->2->1->0, state=6, game_over=1; a start edge then gives lives=3, level=0.
REQ-040 In PLAY, bricks=0 and ball_lost in the same clock -> WIN taken, level=1, lives unchanged, clear_req pulse; step_en then on every tick (N=1).
REQ-041 PAUSE_EN defined: pause edge in PLAY -> state=3 and 5 ticks give no step_en; a second pause edge -> state=2 and the step phase resumes. Undefined: the same stimulus keeps state=2.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Game sequencer bus: player/game-event inputs toward the sequencer and
// the sequencer's registered control outputs back to the game datapath.
// The master side drives the events; the sequencer is the slave.
interface game_sequencer_if;
    logic        tick;
    logic        start_key;
    logic        pause_key;
    logic        ball_lost;
    logic [55:0] bricks;

    logic [2:0]  state;
    logic        step_en;
    logic        serve_req;
    logic        clear_req;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic        game_over;

    modport master (
        output tick, start_key, pause_key, ball_lost, bricks,
        input  state, step_en, serve_req, clear_req, lives, level, game_over
    );

    modport slave (
        input  tick, start_key, pause_key, ball_lost, bricks,
        output state, step_en, serve_req, clear_req, lives, level, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Brick-breaker game sequencer.
// Walks the game through IDLE -> SERVE -> PLAY and handles ball loss,
// level clear, game over and (optionally) pause. Every output is a flop,
// so each reaction shows up one clock after the input that caused it;
// step_en is raised on the edge that samples the qualifying tick.
// Optional feature: define GAME_SEQUENCER_PAUSE_EN to enable the PAUSE
// state. Without it pause_key is ignored and state never reads 3.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 4,
    parameter int STEP_DIV    = 2
) (
    input  logic              clock,
    input  logic              reset,
    game_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_LOST  = 3'd4,
        ST_WIN   = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [3:0] SERVE_LAST = 4'(SERVE_TICKS - 1);
    localparam logic [4:0] DIV_EXT    = 5'(STEP_DIV);
    localparam logic [2:0] LEVEL_MAX  = 3'd7;

    state_t      state_q, state_d;
    logic [3:0]  serve_cnt_q, serve_cnt_d;
    logic [3:0]  step_cnt_q, step_cnt_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic        step_en_q, step_en_d;
    logic        serve_req_q, serve_req_d;
    logic        clear_req_q, clear_req_d;
    logic        game_over_q, game_over_d;

    logic        start_prev_q, start_prev_d;
    logic        start_edge;
    logic [3:0]  step_n;
    logic        step_last;

`ifdef GAME_SEQUENCER_PAUSE_EN
    logic        pause_prev_q, pause_prev_d;
    logic        pause_edge;

    // One pause press is one toggle event: rising edge against last sample
    always_comb begin
        pause_prev_d = bus.pause_key;
        pause_edge   = bus.pause_key & ~pause_prev_q;
    end

    // Previous-value register for the pause key
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pause_prev_q <= 1'b0;
        end else begin
            pause_prev_q <= pause_prev_d;
        end
    end
`else
    logic        unused_pause_key;
    assign unused_pause_key = bus.pause_key;
`endif

    // Start press edge detect and the per-level step divider N = max(1, STEP_DIV - level)
    always_comb begin
        start_prev_d = bus.start_key;
        start_edge   = bus.start_key & ~start_prev_q;
        if (DIV_EXT > {2'b00, level_q}) begin
            step_n = 4'(DIV_EXT - {2'b00, level_q});
        end else begin
            step_n = 4'd1;
        end
        step_last = (step_cnt_q >= (step_n - 4'd1));
    end

    // Next-state and next-output logic for the game flow
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        step_cnt_d  = step_cnt_q;
        lives_d     = lives_q;
        level_d     = level_q;
        step_en_d   = 1'b0;
        clear_req_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d     = ST_SERVE;
                    clear_req_d = 1'b1;
                    lives_d     = LIVES_INIT;
                    level_d     = 3'd0;
                end
            end

            ST_SERVE: begin
                if (bus.tick) begin
                    if (serve_cnt_q >= SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 4'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (bus.bricks == '0) begin
                    state_d = ST_WIN;
                end else if (bus.ball_lost) begin
                    state_d = ST_LOST;
                end
`ifdef GAME_SEQUENCER_PAUSE_EN
                else if (pause_edge) begin
                    state_d = ST_PAUSE;
                end
`endif
                else if (bus.tick) begin
                    if (step_last) begin
                        step_en_d  = 1'b1;
                        step_cnt_d = 4'd0;
                    end else begin
                        step_cnt_d = step_cnt_q + 4'd1;
                    end
                end
            end

`ifdef GAME_SEQUENCER_PAUSE_EN
            ST_PAUSE: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end else if (pause_edge) begin
                    state_d = ST_PLAY;
                end
            end
`endif

            ST_LOST: begin
                if (lives_q <= 2'd1) begin
                    lives_d = 2'd0;
                    state_d = ST_OVER;
                end else begin
                    lives_d = lives_q - 2'd1;
                    state_d = ST_SERVE;
                end
            end

            ST_WIN: begin
                if (level_q != LEVEL_MAX) begin
                    level_d = level_q + 3'd1;
                end
                clear_req_d = 1'b1;
                state_d     = ST_SERVE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state change restarts the serve tick count
        if (state_d != state_q) begin
            serve_cnt_d = 4'd0;
        end

        // A fresh PLAY starts the step phase over; returning from PAUSE keeps it
        if ((state_d == ST_PLAY) && (state_q != ST_PLAY) && (state_q != ST_PAUSE)) begin
            step_cnt_d = 4'd0;
        end

        serve_req_d = (state_d == ST_SERVE);
        game_over_d = (state_d == ST_OVER);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            serve_cnt_q  <= 4'd0;
            step_cnt_q   <= 4'd0;
            lives_q      <= 2'd0;
            level_q      <= 3'd0;
            step_en_q    <= 1'b0;
            serve_req_q  <= 1'b0;
            clear_req_q  <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            step_cnt_q   <= step_cnt_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            step_en_q    <= step_en_d;
            serve_req_q  <= serve_req_d;
            clear_req_q  <= clear_req_d;
            game_over_q  <= game_over_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.step_en   = step_en_q;
    assign bus.serve_req = serve_req_q;
    assign bus.clear_req = clear_req_q;
    assign bus.lives     = lives_q;
    assign bus.level     = level_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters
// (LIVES=3, SERVE_TICKS=4, STEP_DIV=2). Expectations for the pause scenario
// follow GAME_SEQUENCER_PAUSE_EN as seen by this compile.
module tb_game_sequencer;

    localparam logic [55:0] BRICKS_FULL = {56{1'b1}};

    logic clock = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic s;

    game_sequencer_if bus ();

    game_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running system clock
    always #5 clock = ~clock;

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One tick pulse followed by an idle cycle; reports step_en seen after the tick edge
    task automatic tick_once(output logic stepped);
        bus.tick = 1'b1;
        cyc();
        stepped = bus.step_en;
        bus.tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.state !== 3'd0 || bus.lives !== 2'd0 || bus.level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got state=%0d lives=%0d level=%0d expected 0/0/0", bus.state, bus.lives, bus.level);
        end
        tests_run++;
        if ({bus.step_en, bus.serve_req, bus.clear_req, bus.game_over} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.step_en, bus.serve_req, bus.clear_req, bus.game_over});
        end
        reset = 1'b1;
        cyc(); cyc(); cyc();
        tests_run++;
        if (bus.state !== 3'd0 || bus.clear_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got state=%0d clear=%b expected 0/0", bus.state, bus.clear_req);
        end
    endtask

    task automatic test_start_serve_play();
        bus.start_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd1 || bus.clear_req !== 1'b1 || bus.lives !== 2'd3 || bus.serve_req !== 1'b1 || bus.level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL start: got state=%0d clear=%b lives=%0d serve=%b level=%0d expected 1/1/3/1/0",
                     bus.state, bus.clear_req, bus.lives, bus.serve_req, bus.level);
        end
        bus.start_key = 1'b0;
        cyc();
        tests_run++;
        if (bus.clear_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clear_pulse_width: got %b expected 0", bus.clear_req);
        end
        for (int i = 0; i < 4; i++) begin
            tick_once(s);
            tests_run++;
            if (bus.state !== ((i == 3) ? 3'd2 : 3'd1)) begin
                tests_failed++;
                $display("[TB] FAIL serve_tick%0d: got state=%0d expected %0d", i, bus.state, (i == 3) ? 2 : 1);
            end
        end
        tests_run++;
        if (bus.serve_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL serve_req_drop: got %b expected 0", bus.serve_req);
        end
        for (int i = 0; i < 6; i++) begin
            tick_once(s);
            tests_run++;
            if (s !== ((i % 2) == 1)) begin
                tests_failed++;
                $display("[TB] FAIL step_div2_tick%0d: got step_en=%b expected %b", i, s, (i % 2) == 1);
            end
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_state;
        logic       exp_step;
        tick_once(s);
        tests_run++;
        if (s !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pause_pre_tick: got step_en=%b expected 0", s);
        end
`ifdef GAME_SEQUENCER_PAUSE_EN
        exp_state = 3'd3;
`else
        exp_state = 3'd2;
`endif
        bus.pause_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== exp_state) begin
            tests_failed++;
            $display("[TB] FAIL pause_enter: got state=%0d expected %0d", bus.state, exp_state);
        end
        for (int i = 0; i < 5; i++) begin
            tick_once(s);
`ifdef GAME_SEQUENCER_PAUSE_EN
            exp_step = 1'b0;
`else
            exp_step = ((i % 2) == 0);
`endif
            tests_run++;
            if (s !== exp_step) begin
                tests_failed++;
                $display("[TB] FAIL pause_tick%0d: got step_en=%b expected %b", i, s, exp_step);
            end
        end
        bus.pause_key = 1'b0;
        cyc();
        bus.pause_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL pause_resume: got state=%0d expected 2", bus.state);
        end
        bus.pause_key = 1'b0;
        tick_once(s);
`ifdef GAME_SEQUENCER_PAUSE_EN
        exp_step = 1'b1;
`else
        exp_step = 1'b0;
`endif
        tests_run++;
        if (s !== exp_step) begin
            tests_failed++;
            $display("[TB] FAIL resume_phase: got step_en=%b expected %b", s, exp_step);
        end
`ifdef GAME_SEQUENCER_PAUSE_EN
        tick_once(s);
        tests_run++;
        if (s !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resume_next: got step_en=%b expected 0", s);
        end
`endif
    endtask

    task automatic test_lives();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick_once(s);
                tests_run++;
                if (s !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL lives_pre_tick%0d: got step_en=%b expected 0", i, s);
                end
            end
            bus.ball_lost = 1'b1;
            bus.tick      = 1'b1;
            cyc();
            tests_run++;
            if (bus.state !== 3'd4 || bus.step_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL lost%0d: got state=%0d step_en=%b expected 4/0", i, bus.state, bus.step_en);
            end
            bus.ball_lost = 1'b0;
            bus.tick      = 1'b0;
            cyc();
            tests_run++;
            if (bus.lives !== 2'(2 - i)) begin
                tests_failed++;
                $display("[TB] FAIL lives_after%0d: got %0d expected %0d", i, bus.lives, 2 - i);
            end
            if (i < 2) begin
                tests_run++;
                if (bus.state !== 3'd1) begin
                    tests_failed++;
                    $display("[TB] FAIL reserve%0d: got state=%0d expected 1", i, bus.state);
                end
                for (int k = 0; k < 4; k++) tick_once(s);
                tests_run++;
                if (bus.state !== 3'd2) begin
                    tests_failed++;
                    $display("[TB] FAIL replay%0d: got state=%0d expected 2", i, bus.state);
                end
            end else begin
                tests_run++;
                if (bus.state !== 3'd6 || bus.game_over !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL game_over: got state=%0d game_over=%b expected 6/1", bus.state, bus.game_over);
                end
            end
        end
        cyc(); cyc();
        tests_run++;
        if (bus.state !== 3'd6) begin
            tests_failed++;
            $display("[TB] FAIL over_hold: got state=%0d expected 6", bus.state);
        end
        bus.start_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd1 || bus.lives !== 2'd3 || bus.level !== 3'd0 || bus.clear_req !== 1'b1 || bus.game_over !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL restart: got state=%0d lives=%0d level=%0d clear=%b over=%b expected 1/3/0/1/0",
                     bus.state, bus.lives, bus.level, bus.clear_req, bus.game_over);
        end
        bus.start_key = 1'b0;
        for (int k = 0; k < 4; k++) tick_once(s);
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL restart_play: got state=%0d expected 2", bus.state);
        end
    endtask

    task automatic test_win();
        bus.bricks    = '0;
        bus.ball_lost = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd5 || bus.lives !== 2'd3 || bus.step_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL win_priority: got state=%0d lives=%0d step_en=%b expected 5/3/0", bus.state, bus.lives, bus.step_en);
        end
        bus.bricks    = BRICKS_FULL;
        bus.ball_lost = 1'b0;
        cyc();
        tests_run++;
        if (bus.state !== 3'd1 || bus.level !== 3'd1 || bus.lives !== 2'd3 || bus.clear_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL win_next: got state=%0d level=%0d lives=%0d clear=%b expected 1/1/3/1",
                     bus.state, bus.level, bus.lives, bus.clear_req);
        end
        bus.ball_lost = 1'b1;
        cyc();
        bus.ball_lost = 1'b0;
        bus.bricks    = '0;
        cyc();
        bus.bricks    = BRICKS_FULL;
        cyc();
        tests_run++;
        if (bus.state !== 3'd1 || bus.lives !== 2'd3 || bus.clear_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ignore_outside_play: got state=%0d lives=%0d clear=%b expected 1/3/0", bus.state, bus.lives, bus.clear_req);
        end
        for (int k = 0; k < 4; k++) tick_once(s);
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL win_play: got state=%0d expected 2", bus.state);
        end
        for (int i = 0; i < 3; i++) begin
            tick_once(s);
            tests_run++;
            if (s !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL step_div1_tick%0d: got step_en=%b expected 1", i, s);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        bus.tick = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.state !== 3'd0 || bus.lives !== 2'd0 || bus.level !== 3'd0 || bus.step_en !== 1'b0 || bus.clear_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_play: got state=%0d lives=%0d level=%0d step=%b clear=%b expected 0/0/0/0/0",
                     bus.state, bus.lives, bus.level, bus.step_en, bus.clear_req);
        end
        bus.tick = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick_once(s);
        tests_run++;
        if (bus.state !== 3'd0 || bus.clear_req !== 1'b0 || bus.step_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got state=%0d clear=%b step=%b expected 0/0/0", bus.state, bus.clear_req, bus.step_en);
        end
        bus.start_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd1 || bus.lives !== 2'd3 || bus.level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL start_after_reset: got state=%0d lives=%0d level=%0d expected 1/3/0", bus.state, bus.lives, bus.level);
        end
        bus.start_key = 1'b0;
        for (int k = 0; k < 4; k++) tick_once(s);
    endtask

    task automatic test_pause_abort();
        bus.pause_key = 1'b1;
        cyc();
`ifdef GAME_SEQUENCER_PAUSE_EN
        tests_run++;
        if (bus.state !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL abort_pause: got state=%0d expected 3", bus.state);
        end
        bus.pause_key = 1'b0;
        bus.start_key = 1'b1;
        cyc();
        tests_run++;
        if (bus.state !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL abort_to_idle: got state=%0d expected 0", bus.state);
        end
`else
        tests_run++;
        if (bus.state !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL no_pause_state: got state=%0d expected 2", bus.state);
        end
`endif
        bus.pause_key = 1'b0;
        bus.start_key = 1'b0;
        cyc();
    endtask

    // Scenario sequence
    initial begin
        reset         = 1'b0;
        bus.tick      = 1'b0;
        bus.start_key = 1'b0;
        bus.pause_key = 1'b0;
        bus.ball_lost = 1'b0;
        bus.bricks    = BRICKS_FULL;
        cyc(); cyc(); cyc();
        test_reset();
        test_start_serve_play();
        test_pause();
        test_lives();
        test_win();
        test_reset_mid_play();
        test_pause_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
